// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with pulse, hold, sweep and clear modes.
// Define DECODER_ERR_EN to add a sticky out-of-range error flag (err) and its clear input (clr_err).
module decoder_onehot_seq #(
    parameter int SEL_W     = 5,
    parameter int OUT_W     = 32,
    parameter int PULSE_LEN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic [1:0]       mode,
    output logic             ready,
    output logic [OUT_W-1:0] decoded,
    output logic             done
`ifdef DECODER_ERR_EN
    ,
    input  logic             clr_err,
    output logic             err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLD, S_SWEEP} state_t;

    localparam logic [1:0] M_PULSE = 2'b00;
    localparam logic [1:0] M_HOLD  = 2'b01;
    localparam logic [1:0] M_SWEEP = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    localparam int              OUT_W_I  = OUT_W;
    localparam int              LAST_I   = OUT_W - 1;
    localparam int              CNT_I    = PULSE_LEN - 1;
    localparam logic [SEL_W:0]  OUT_LIM  = OUT_W_I[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST_IDX = LAST_I[SEL_W-1:0];
    localparam logic [7:0]      CNT_INIT = CNT_I[7:0];

    state_t           state;
    logic [7:0]       cnt;
    logic [SEL_W-1:0] idx;
    logic             in_range;
    logic             req;
    logic             accept;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
        return {{(OUT_W-1){1'b0}}, 1'b1} << s;
    endfunction

    // ready comes straight from state so it reads 1 while the async reset holds state at IDLE
    assign ready    = (state == S_IDLE) || (state == S_HOLD);
    assign in_range = {1'b0, sel} < OUT_LIM;
    assign req      = en && ready;
    assign accept   = req && ((mode == M_CLEAR) || in_range);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            decoded <= '0;
            done    <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                // HOLD accepts new requests exactly like IDLE, replacing the line in one edge
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        case (mode)
                            M_PULSE: begin
                                decoded <= onehot(sel);
                                cnt     <= CNT_INIT;
                                state   <= S_PULSE;
                            end
                            M_HOLD: begin
                                decoded <= onehot(sel);
                                state   <= S_HOLD;
                            end
                            M_SWEEP: begin
                                decoded <= onehot(sel);
                                idx     <= sel;
                                state   <= S_SWEEP;
                            end
                            default: begin
                                decoded <= '0;
                                state   <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_PULSE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        decoded <= '0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_SWEEP: begin
                    if (idx == LAST_IDX) begin
                        decoded <= '0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        idx     <= idx + {{(SEL_W-1){1'b0}}, 1'b1};
                        decoded <= decoded << 1;
                    end
                end
                default: begin
                    decoded <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DECODER_ERR_EN
    // A rejected request sets err; set takes priority over a same-edge clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (req && (mode != M_CLEAR) && !in_range) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Self-checking bench for decoder_onehot_seq: three instances (32/PL1, 32/PL4, 20/PL3) share stimulus
// and are scored each cycle against a line/countdown reference model.
module tb_decoder_onehot_seq;

    localparam int K_IDLE  = 0;
    localparam int K_PULSE = 1;
    localparam int K_HOLD  = 2;
    localparam int K_SWEEP = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [4:0] sel   = '0;
    logic [1:0] mode  = '0;

    logic [31:0] dec_a, dec_b;
    logic [19:0] dec_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;

    int m_kind [3];
    int m_line [3];
    int m_rem  [3];
    bit m_done [3];

`ifdef DECODER_ERR_EN
    logic clr_err = 1'b0;
    logic err_a, err_b, err_c;
    bit   m_err [3];
`endif

    always #5 clk = ~clk;

    decoder_onehot_seq #(.SEL_W(5), .OUT_W(32), .PULSE_LEN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .mode(mode),
        .ready(rdy_a), .decoded(dec_a), .done(done_a)
`ifdef DECODER_ERR_EN
        , .clr_err(clr_err), .err(err_a)
`endif
    );

    decoder_onehot_seq #(.SEL_W(5), .OUT_W(32), .PULSE_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .mode(mode),
        .ready(rdy_b), .decoded(dec_b), .done(done_b)
`ifdef DECODER_ERR_EN
        , .clr_err(clr_err), .err(err_b)
`endif
    );

    decoder_onehot_seq #(.SEL_W(5), .OUT_W(20), .PULSE_LEN(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .mode(mode),
        .ready(rdy_c), .decoded(dec_c), .done(done_c)
`ifdef DECODER_ERR_EN
        , .clr_err(clr_err), .err(err_c)
`endif
    );

    function automatic int ow(int k);
        return (k == 2) ? 20 : 32;
    endfunction

    function automatic int pl(int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 3);
    endfunction

    function automatic logic [31:0] dec_of(int k);
        if (k == 0) return dec_a;
        if (k == 1) return dec_b;
        return {12'd0, dec_c};
    endfunction

    function automatic logic rdy_of(int k);
        return (k == 0) ? rdy_a : ((k == 1) ? rdy_b : rdy_c);
    endfunction

    function automatic logic done_of(int k);
        return (k == 0) ? done_a : ((k == 1) ? done_b : done_c);
    endfunction

`ifdef DECODER_ERR_EN
    function automatic logic err_of(int k);
        return (k == 0) ? err_a : ((k == 1) ? err_b : err_c);
    endfunction
`endif

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_kind[k] = K_IDLE;
            m_line[k] = -1;
            m_rem[k]  = 0;
            m_done[k] = 1'b0;
`ifdef DECODER_ERR_EN
            m_err[k]  = 1'b0;
`endif
        end
    endfunction

    // One clock edge of the reference: the lit line number plus cycles left, from the mode rules.
    function automatic void model_step();
        for (int k = 0; k < 3; k++) begin
            bit rdy;
            rdy = (m_kind[k] == K_IDLE) || (m_kind[k] == K_HOLD);
`ifdef DECODER_ERR_EN
            if (en && rdy && mode != 2'b11 && int'(sel) >= ow(k)) m_err[k] = 1'b1;
            else if (clr_err) m_err[k] = 1'b0;
`endif
            m_done[k] = 1'b0;
            if (m_kind[k] == K_PULSE) begin
                m_rem[k] = m_rem[k] - 1;
                if (m_rem[k] == 0) begin
                    m_line[k] = -1;
                    m_kind[k] = K_IDLE;
                    m_done[k] = 1'b1;
                end
            end else if (m_kind[k] == K_SWEEP) begin
                m_line[k] = m_line[k] + 1;
                if (m_line[k] >= ow(k)) begin
                    m_line[k] = -1;
                    m_kind[k] = K_IDLE;
                    m_done[k] = 1'b1;
                end
            end else if (en) begin
                if (mode == 2'b11) begin
                    m_line[k] = -1;
                    m_kind[k] = K_IDLE;
                end else if (int'(sel) < ow(k)) begin
                    m_line[k] = int'(sel);
                    m_rem[k]  = pl(k);
                    m_kind[k] = (mode == 2'b00) ? K_PULSE : ((mode == 2'b01) ? K_HOLD : K_SWEEP);
                end
            end
        end
    endfunction

    // Advance one clock, update the reference, then score every instance 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_dec;
            logic        exp_rdy;
            exp_dec = (m_line[k] < 0) ? 32'd0 : (32'd1 << m_line[k]);
            exp_rdy = (m_kind[k] == K_IDLE) || (m_kind[k] == K_HOLD);
            checks++;
            if (dec_of(k) !== exp_dec) begin
                errors++;
                $display("FAIL model_decoded dut%0d t=%0t got %h expected %h", k, $time, dec_of(k), exp_dec);
            end
            checks++;
            if (rdy_of(k) !== exp_rdy) begin
                errors++;
                $display("FAIL model_ready dut%0d t=%0t got %b expected %b", k, $time, rdy_of(k), exp_rdy);
            end
            checks++;
            if (done_of(k) !== m_done[k]) begin
                errors++;
                $display("FAIL model_done dut%0d t=%0t got %b expected %b", k, $time, done_of(k), m_done[k]);
            end
            checks++;
            if ($countones(dec_of(k)) > 1) begin
                errors++;
                $display("FAIL onehot_invariant dut%0d t=%0t got %h expected at most one bit", k, $time, dec_of(k));
            end
`ifdef DECODER_ERR_EN
            checks++;
            if (err_of(k) !== m_err[k]) begin
                errors++;
                $display("FAIL model_err dut%0d t=%0t got %b expected %b", k, $time, err_of(k), m_err[k]);
            end
`endif
        end
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dec_of(k) !== 32'd0 || rdy_of(k) !== 1'b1 || done_of(k) !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d got dec=%h rdy=%b done=%b expected dec=0 rdy=1 done=0",
                         k, dec_of(k), rdy_of(k), done_of(k));
            end
        end
        #4 rst_n = 1'b1;
    endtask

    task automatic test_pulse_len1();
        en = 1'b1; sel = 5'd3; mode = 2'b00;
        tick();
        en = 1'b0;
        checks++;
        if (dec_a !== 32'h0000_0008 || rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL pulse1_high got dec=%h rdy=%b expected dec=00000008 rdy=0", dec_a, rdy_a);
        end
        tick();
        checks++;
        if (dec_a !== 32'h0 || done_a !== 1'b1 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL pulse1_end got dec=%h done=%b rdy=%b expected dec=0 done=1 rdy=1", dec_a, done_a, rdy_a);
        end
        repeat (5) tick();
    endtask

    task automatic test_pulse_len4();
        en = 1'b1; sel = 5'd31; mode = 2'b00;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dec_b !== 32'h8000_0000) begin
                errors++;
                $display("FAIL pulse4_high cycle%0d got %h expected 80000000", i, dec_b);
            end
            en = (i == 0 || i == 1); sel = 5'd7; mode = 2'b01;
            tick();
        end
        en = 1'b0;
        checks++;
        if (dec_b !== 32'h0 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL pulse4_end got dec=%h done=%b expected dec=0 done=1", dec_b, done_b);
        end
        en = 1'b1; mode = 2'b11;
        tick();
        en = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_hold();
        en = 1'b1; sel = 5'd5; mode = 2'b01;
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dec_a !== 32'h20) begin
                errors++;
                $display("FAIL hold5 cycle%0d got %h expected 00000020", i, dec_a);
            end
            tick();
        end
        en = 1'b1; sel = 5'd6; mode = 2'b01;
        tick();
        checks++;
        if (dec_a !== 32'h40) begin
            errors++;
            $display("FAIL hold_replace got %h expected 00000040", dec_a);
        end
        mode = 2'b11;
        tick();
        en = 1'b0;
        checks++;
        if (dec_a !== 32'h0 || done_a !== 1'b0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL hold_clear got dec=%h done=%b rdy=%b expected dec=0 done=0 rdy=1", dec_a, done_a, rdy_a);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h2000_0000;
        exp_seq[1] = 32'h4000_0000;
        exp_seq[2] = 32'h8000_0000;
        en = 1'b1; sel = 5'd29; mode = 2'b10;
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dec_a !== exp_seq[i] || done_a !== 1'b0) begin
                errors++;
                $display("FAIL sweep29 step%0d got dec=%h done=%b expected dec=%h done=0", i, dec_a, done_a, exp_seq[i]);
            end
            tick();
        end
        checks++;
        if (dec_a !== 32'h0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL sweep29_end got dec=%h done=%b expected dec=0 done=1", dec_a, done_a);
        end
        en = 1'b1; sel = 5'd31; mode = 2'b10;
        tick();
        en = 1'b0;
        checks++;
        if (dec_a !== 32'h8000_0000 || rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL sweep31_line got dec=%h rdy=%b expected dec=80000000 rdy=0", dec_a, rdy_a);
        end
        tick();
        checks++;
        if (dec_a !== 32'h0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL sweep31_end got dec=%h done=%b expected dec=0 done=1", dec_a, done_a);
        end
        repeat (2) tick();
    endtask

    task automatic test_out_of_range();
        en = 1'b1; sel = 5'd3; mode = 2'b01;
        tick();
        sel = 5'd25;
        tick();
        en = 1'b0;
        checks++;
        if (dec_c !== 20'h8 || rdy_c !== 1'b1 || done_c !== 1'b0) begin
            errors++;
            $display("FAIL oor_unchanged got dec=%h rdy=%b done=%b expected dec=00008 rdy=1 done=0", dec_c, rdy_c, done_c);
        end
`ifdef DECODER_ERR_EN
        checks++;
        if (err_c !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_set got %b expected 1", err_c);
        end
        repeat (3) tick();
        checks++;
        if (err_c !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_sticky got %b expected 1", err_c);
        end
        en = 1'b1; clr_err = 1'b1;
        tick();
        checks++;
        if (err_c !== 1'b1) begin
            errors++;
            $display("FAIL oor_set_wins got %b expected 1", err_c);
        end
        en = 1'b0;
        tick();
        clr_err = 1'b0;
        checks++;
        if (err_c !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_clear got %b expected 0", err_c);
        end
`else
        repeat (3) tick();
        checks++;
        if (dec_c !== 20'h8) begin
            errors++;
            $display("FAIL oor_still_held got %h expected 00008", dec_c);
        end
`endif
        en = 1'b1; mode = 2'b11;
        tick();
        en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        en = 1'b1; sel = 5'd10; mode = 2'b10;
        tick();
        en = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dec_of(k) !== 32'd0 || rdy_of(k) !== 1'b1 || done_of(k) !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dut%0d got dec=%h rdy=%b done=%b expected dec=0 rdy=1 done=0",
                         k, dec_of(k), rdy_of(k), done_of(k));
            end
        end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if (done_a !== 1'b0 || done_b !== 1'b0) begin
                errors++;
                $display("FAIL no_done_after_reset cycle%0d got a=%b b=%b expected 0", i, done_a, done_b);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            sel  = 5'($urandom_range(0, 31));
            mode = 2'($urandom_range(0, 3));
`ifdef DECODER_ERR_EN
            clr_err = ($urandom_range(0, 7) == 0);
`endif
            if (i % 150 == 75) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
                model_reset();
            end
            tick();
        end
        en = 1'b0;
`ifdef DECODER_ERR_EN
        clr_err = 1'b0;
`endif
        repeat (40) tick();
    endtask

    initial begin
        test_reset();
        test_pulse_len1();
        test_pulse_len4();
        test_hold();
        test_sweep();
        test_out_of_range();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
